// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-bank slave: FSM state codes and
// the bus condition codes reported by the synchroniser.
package i2c_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_FETCH     = 4'd7;
    localparam logic [3:0] ST_RDATA     = 4'd8;
    localparam logic [3:0] ST_RACK      = 4'd9;

    typedef enum logic [1:0] {
        COND_NONE  = 2'd0,
        COND_START = 2'd1,
        COND_STOP  = 2'd2
    } bus_cond_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with registered SCL edge and START/STOP detection.
// All detection works on the synchronised levels only.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      scl_in,
    input  logic      sda_in,
    output logic      scl_rise,
    output logic      scl_fall,
    output logic      sda_lvl,
    output bus_cond_e cond
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_d_r;
    logic                   sda_d_r;
    logic                   scl_rise_r;
    logic                   scl_fall_r;
    logic                   sda_lvl_r;
    bus_cond_e              cond_r;
    logic                   scl_s;
    logic                   sda_s;
    logic                   start_s;
    logic                   stop_s;

    assign scl_s   = scl_sync_r[SYNC_STAGES-1];
    assign sda_s   = sda_sync_r[SYNC_STAGES-1];
    // SDA moving while SCL stays high marks a bus condition
    assign start_s = scl_s & scl_d_r &  sda_d_r & ~sda_s;
    assign stop_s  = scl_s & scl_d_r & ~sda_d_r &  sda_s;

    // Metastability chains; an idle bus is high, so they reset to 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
        end
    end

    // Previous-level copies and registered edge/condition outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            sda_lvl_r  <= 1'b1;
            cond_r     <= COND_NONE;
        end else begin
            scl_d_r    <= scl_s;
            sda_d_r    <= sda_s;
            scl_rise_r <= scl_s & ~scl_d_r;
            scl_fall_r <= ~scl_s & scl_d_r;
            sda_lvl_r  <= sda_s;
            if (start_s) begin
                cond_r <= COND_START;
            end else if (stop_s) begin
                cond_r <= COND_STOP;
            end else begin
                cond_r <= COND_NONE;
            end
        end
    end

    assign scl_rise = scl_rise_r;
    assign scl_fall = scl_fall_r;
    assign sda_lvl  = sda_lvl_r;
    assign cond     = cond_r;

endmodule

// File: rtl/i2c_slave_regbank.sv
// I2C slave exposing a register bank: first written byte sets the register
// pointer, further written bytes are stored, reads fetch through a
// request/valid handshake while stretching SCL.
module i2c_slave_regbank
    import i2c_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int SYNC_STAGES = 2,
    parameter int WRAP_EN     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              scl_oe,
    output logic              sda_oe,
    input  logic [6:0]        slave_addr,
    input  logic              enable,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_rvalid,
    output logic              busy,
    output logic              stop_det
);

    localparam logic [REG_AW-1:0] PTR_MAX = {REG_AW{1'b1}};
    localparam logic [REG_AW-1:0] PTR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

    // Pointer advance: wrap to 0 or saturate at the top register
    function automatic logic [REG_AW-1:0] ptr_next(input logic [REG_AW-1:0] p);
        if (p == PTR_MAX) begin
            ptr_next = (WRAP_EN != 0) ? {REG_AW{1'b0}} : p;
        end else begin
            ptr_next = p + PTR_ONE;
        end
    endfunction

    logic              scl_rise_s;
    logic              scl_fall_s;
    logic              sda_lvl_s;
    bus_cond_e         cond_s;

    logic [3:0]        state_r;
    logic [7:0]        shift_r;
    logic [7:0]        tx_r;
    logic [3:0]        bit_cnt_r;
    logic              rw_r;
    logic              ack_r;
    logic [REG_AW-1:0] ptr_r;
    logic [REG_AW-1:0] reg_addr_r;
    logic [7:0]        reg_wdata_r;
    logic              reg_we_r;
    logic              reg_re_r;
    logic              scl_oe_r;
    logic              sda_oe_r;
    logic              busy_r;
    logic              stop_det_r;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .sda_lvl  (sda_lvl_s),
        .cond     (cond_s)
    );

    // Protocol FSM, byte shifters, pointer and register-port strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            shift_r     <= 8'h00;
            tx_r        <= 8'h00;
            bit_cnt_r   <= 4'd0;
            rw_r        <= 1'b0;
            ack_r       <= 1'b0;
            ptr_r       <= {REG_AW{1'b0}};
            reg_addr_r  <= {REG_AW{1'b0}};
            reg_wdata_r <= 8'h00;
            reg_we_r    <= 1'b0;
            reg_re_r    <= 1'b0;
            scl_oe_r    <= 1'b0;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            stop_det_r  <= 1'b0;
        end else begin
            reg_we_r   <= 1'b0;
            reg_re_r   <= 1'b0;
            stop_det_r <= 1'b0;
            // a stored byte moves the pointer on in the clock after its strobe
            if (reg_we_r) begin
                ptr_r <= ptr_next(ptr_r);
            end
            if (cond_s == COND_STOP) begin
                state_r    <= ST_IDLE;
                scl_oe_r   <= 1'b0;
                sda_oe_r   <= 1'b0;
                stop_det_r <= busy_r;
                busy_r     <= 1'b0;
            end else if (cond_s == COND_START) begin
                // abandons any partial byte; busy survives a repeated START
                state_r   <= ST_ADDR;
                bit_cnt_r <= 4'd0;
                scl_oe_r  <= 1'b0;
                sda_oe_r  <= 1'b0;
            end else if (!enable && (state_r != ST_IDLE)) begin
                state_r  <= ST_IDLE;
                scl_oe_r <= 1'b0;
                sda_oe_r <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
                            shift_r   <= {shift_r[6:0], sda_lvl_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if ((state_r == ST_WDATA) && (bit_cnt_r == 4'd7)) begin
                                reg_wdata_r <= {shift_r[6:0], sda_lvl_s};
                                reg_addr_r  <= ptr_r;
                                reg_we_r    <= 1'b1;
                            end
                        end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                            if (state_r == ST_ADDR) begin
                                if (enable && (shift_r[7:1] == slave_addr) &&
                                    (shift_r[7:1] != 7'd0)) begin
                                    rw_r     <= shift_r[0];
                                    sda_oe_r <= 1'b1;
                                    busy_r   <= 1'b1;
                                    state_r  <= ST_ADDR_ACK;
                                end else begin
                                    sda_oe_r <= 1'b0;
                                    busy_r   <= 1'b0;
                                    state_r  <= ST_IDLE;
                                end
                            end else if (state_r == ST_PTR) begin
                                ptr_r    <= shift_r[REG_AW-1:0];
                                sda_oe_r <= 1'b1;
                                state_r  <= ST_PTR_ACK;
                            end else begin
                                sda_oe_r <= 1'b1;
                                state_r  <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            sda_oe_r  <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            if (rw_r) begin
                                reg_re_r   <= 1'b1;
                                reg_addr_r <= ptr_r;
                                scl_oe_r   <= 1'b1;
                                state_r    <= ST_FETCH;
                            end else begin
                                state_r <= ST_PTR;
                            end
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall_s) begin
                            sda_oe_r  <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_WDATA;
                        end
                    end
                    ST_FETCH: begin
                        // SCL is held low until the register bank answers
                        if (reg_rvalid) begin
                            tx_r      <= reg_rdata;
                            sda_oe_r  <= ~reg_rdata[7];
                            scl_oe_r  <= 1'b0;
                            ptr_r     <= ptr_next(ptr_r);
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd7) begin
                                sda_oe_r <= 1'b0;
                                state_r  <= ST_RACK;
                            end else begin
                                tx_r      <= {tx_r[6:0], 1'b0};
                                sda_oe_r  <= ~tx_r[6];
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_RACK: begin
                        if (scl_rise_s) begin
                            ack_r <= ~sda_lvl_s;
                        end else if (scl_fall_s) begin
                            if (ack_r) begin
                                reg_re_r   <= 1'b1;
                                reg_addr_r <= ptr_r;
                                scl_oe_r   <= 1'b1;
                                state_r    <= ST_FETCH;
                            end else begin
                                busy_r  <= 1'b0;
                                state_r <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        scl_oe_r <= 1'b0;
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign scl_oe    = scl_oe_r;
    assign sda_oe    = sda_oe_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_we    = reg_we_r;
    assign reg_re    = reg_re_r;
    assign busy      = busy_r;
    assign stop_det  = stop_det_r;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: bit-banged I2C master on a wired-AND bus
// shared by a wrapping instance (u0) and a saturating instance (u1),
// scoreboards for register writes/reads and a delayed read responder.
module tb_i2c_slave_regbank;

    localparam int T = 120;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       mscl;
    logic       msda;
    logic       scl_line;
    logic       sda_line;
    logic       en0;
    logic       en1;
    logic [6:0] slave0;
    logic [6:0] slave1 = 7'h3C;

    logic       scl_oe0, sda_oe0, we0, re0, busy0, sd0;
    logic [4:0] addr0;
    logic [7:0] wdata0;
    logic [7:0] rdata0  = 8'h00;
    logic       rvalid0 = 1'b0;

    logic       scl_oe1, sda_oe1, we1, re1, busy1, sd1;
    logic [4:0] addr1;
    logic [7:0] wdata1;
    logic [7:0] rdata1  = 8'h00;
    logic       rvalid1 = 1'b0;

    assign scl_line = mscl & ~scl_oe0 & ~scl_oe1;
    assign sda_line = msda & ~sda_oe0 & ~sda_oe1;

    i2c_slave_regbank #(.REG_AW(5), .SYNC_STAGES(2), .WRAP_EN(1)) u0 (
        .clk(clk), .reset(reset), .scl_in(scl_line), .sda_in(sda_line),
        .scl_oe(scl_oe0), .sda_oe(sda_oe0), .slave_addr(slave0), .enable(en0),
        .reg_addr(addr0), .reg_wdata(wdata0), .reg_we(we0), .reg_re(re0),
        .reg_rdata(rdata0), .reg_rvalid(rvalid0), .busy(busy0), .stop_det(sd0)
    );

    i2c_slave_regbank #(.REG_AW(5), .SYNC_STAGES(3), .WRAP_EN(0)) u1 (
        .clk(clk), .reset(reset), .scl_in(scl_line), .sda_in(sda_line),
        .scl_oe(scl_oe1), .sda_oe(sda_oe1), .slave_addr(slave1), .enable(en1),
        .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1), .reg_re(re1),
        .reg_rdata(rdata1), .reg_rvalid(rvalid1), .busy(busy1), .stop_det(sd1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq0[$];
    wr_t        wq1[$];
    logic [4:0] raq[$];
    logic [7:0] rdq[$];
    int         stop_cnt0  = 0;
    int         stop_cnt1  = 0;
    int         stray_req  = 0;
    int         stray_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // write scoreboards and stop_det pulse counters
    always @(negedge clk) begin : mon
        wr_t e;
        if (we0) begin
            if (wq0.size() == 0) begin
                checks++; errors++;
                $display("FAIL we0_unexpected: addr %0h data %0h expected no write", addr0, wdata0);
            end else begin
                e = wq0.pop_front();
                chk("we0_addr", 32'(addr0), 32'(e.a));
                chk("we0_data", 32'(wdata0), 32'(e.d));
            end
        end
        if (we1) begin
            if (wq1.size() == 0) begin
                checks++; errors++;
                $display("FAIL we1_unexpected: addr %0h data %0h expected no write", addr1, wdata1);
            end else begin
                e = wq1.pop_front();
                chk("we1_addr", 32'(addr1), 32'(e.a));
                chk("we1_data", 32'(wdata1), 32'(e.d));
            end
        end
        if (re1) begin
            checks++; errors++;
            $display("FAIL re1_unexpected: addr %0h expected no read", addr1);
        end
        if (sd0) stop_cnt0++;
        if (sd1) stop_cnt1++;
    end

    // register-bank read responder: answers 10 clocks after reg_re
    always @(negedge clk) begin : resp
        logic [4:0] ea;
        logic [7:0] ed;
        if (re0) begin
            if (raq.size() == 0) begin
                checks++; errors++;
                $display("FAIL re0_unexpected: addr %0h expected no read", addr0);
            end else begin
                ea = raq.pop_front();
                ed = rdq.pop_front();
                chk("re0_addr", 32'(addr0), 32'(ea));
                for (int i = 0; i < 10; i++) begin
                    chk("stretch_hold", 32'(scl_oe0), 32'd1);
                    @(negedge clk);
                end
                rdata0  = ed;
                rvalid0 = 1'b1;
                @(negedge clk);
                chk("stretch_release", 32'(scl_oe0), 32'd0);
                rvalid0 = 1'b0;
            end
        end else if (stray_req != stray_done) begin
            rdata0  = 8'h00;
            rvalid0 = 1'b1;
            @(negedge clk);
            rvalid0    = 1'b0;
            stray_done = stray_req;
        end
    end

    task automatic scl_high();
        int n;
        mscl = 1'b1;
        n = 0;
        while (scl_line !== 1'b1 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (scl_line !== 1'b1) begin
            checks++; errors++;
            $display("FAIL scl_timeout: scl line %0b expected 1", scl_line);
        end
    endtask

    task automatic i2c_start();
        msda = 1'b1; #T;
        scl_high();  #T;
        msda = 1'b0; #T;
        mscl = 1'b0; #T;
    endtask

    task automatic i2c_stop();
        msda = 1'b0; #T;
        scl_high();  #T;
        msda = 1'b1; #T;
    endtask

    task automatic write_bit(input logic b);
        msda = b;    #T;
        scl_high();  #T;
        mscl = 1'b0; #T;
    endtask

    task automatic read_bit(output logic b);
        msda = 1'b1; #T;
        scl_high();  #(T/2);
        b = sda_line; #(T/2);
        mscl = 1'b0; #T;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    typedef struct {
        logic [6:0] sa;
        logic [7:0] abyte;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
    } wvec_t;

    wvec_t tbl [6];

    task automatic run_write(input wvec_t v);
        logic       ack;
        logic [4:0] p;
        int         sc;
        sc = stop_cnt0;
        slave0 = v.sa;
        if (v.exp_ack) begin
            p = v.ptr[4:0];
            wq0.push_back({p, v.d0});
            p = p + 5'd1;
            wq0.push_back({p, v.d1});
        end
        i2c_start();
        write_byte(v.abyte, ack);
        chk("addr_ack", 32'(ack), 32'(v.exp_ack));
        chk("busy_after_addr", 32'(busy0), 32'(v.exp_ack));
        if (v.exp_ack) begin
            write_byte(v.ptr, ack);
            chk("ptr_ack", 32'(ack), 32'd1);
            write_byte(v.d0, ack);
            chk("data0_ack", 32'(ack), 32'd1);
            write_byte(v.d1, ack);
            chk("data1_ack", 32'(ack), 32'd1);
        end
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("stop_det_pulses", 32'(stop_cnt0 - sc), 32'(v.exp_ack));
        chk("busy_after_stop", 32'(busy0), 32'd0);
        chk("writes_drained", 32'(wq0.size()), 32'd0);
        slave0 = 7'h3C;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic       ack;
        logic [7:0] d;
        int         n;
        int         sc;

        reset = 1'b1; mscl = 1'b1; msda = 1'b1;
        en0 = 1'b1; en1 = 1'b0; slave0 = 7'h3C;
        repeat (4) @(negedge clk);
        chk("rst_scl_oe",   32'(scl_oe0), 32'd0);
        chk("rst_sda_oe",   32'(sda_oe0), 32'd0);
        chk("rst_reg_we",   32'(we0),     32'd0);
        chk("rst_reg_re",   32'(re0),     32'd0);
        chk("rst_busy",     32'(busy0),   32'd0);
        chk("rst_stop_det", 32'(sd0),     32'd0);
        chk("rst_wdata",    32'(wdata0),  32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // stray rvalid while idle must change nothing
        stray_req = 1;
        n = 0;
        while (stray_done != 1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("stray_scl_oe", 32'(scl_oe0), 32'd0);
        chk("stray_sda_oe", 32'(sda_oe0), 32'd0);
        chk("stray_busy",   32'(busy0),   32'd0);

        tbl[0] = '{7'h3C, 8'h78, 8'h05, 8'hAA, 8'hBB, 1'b1};
        tbl[1] = '{7'h3C, 8'h7A, 8'h05, 8'h12, 8'h34, 1'b0};
        tbl[2] = '{7'h3C, 8'h00, 8'h05, 8'h12, 8'h34, 1'b0};
        tbl[3] = '{7'h00, 8'h00, 8'h05, 8'h12, 8'h34, 1'b0};
        tbl[4] = '{7'h3C, 8'h78, 8'h1F, 8'h33, 8'h44, 1'b1};
        tbl[5] = '{7'h3C, 8'h78, 8'h10, 8'h55, 8'h66, 1'b1};
        for (int i = 0; i < 6; i++) run_write(tbl[i]);

        // pointer write, repeated START, two-byte read with stretching
        sc = stop_cnt0;
        raq.push_back(5'd31); rdq.push_back(8'h11);
        raq.push_back(5'd0);  rdq.push_back(8'h22);
        i2c_start();
        write_byte(8'h78, ack); chk("rd_addr_w_ack", 32'(ack), 32'd1);
        write_byte(8'h1F, ack); chk("rd_ptr_ack",    32'(ack), 32'd1);
        i2c_start();
        write_byte(8'h79, ack); chk("rd_addr_r_ack", 32'(ack), 32'd1);
        read_byte(d, 1'b1);     chk("rd_byte0", 32'(d), 32'h11);
        read_byte(d, 1'b0);     chk("rd_byte1", 32'(d), 32'h22);
        chk("busy_after_nack", 32'(busy0), 32'd0);
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("rd_reads_drained", 32'(raq.size()), 32'd0);
        chk("rd_stop_det_none", 32'(stop_cnt0 - sc), 32'd0);

        // START four bits into a data byte aborts it without a write
        sc = stop_cnt0;
        i2c_start();
        write_byte(8'h78, ack); chk("ab_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h02, ack); chk("ab_ptr_ack",  32'(ack), 32'd1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_start();
        write_byte(8'h78, ack); chk("ab_readdr_ack", 32'(ack), 32'd1);
        write_byte(8'h07, ack); chk("ab_ptr2_ack",   32'(ack), 32'd1);
        wq0.push_back({5'd7, 8'h5A});
        write_byte(8'h5A, ack); chk("ab_data_ack",   32'(ack), 32'd1);
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("ab_writes_drained", 32'(wq0.size()), 32'd0);
        chk("ab_stop_det", 32'(stop_cnt0 - sc), 32'd1);

        // saturating pointer on the WRAP_EN=0 instance
        en0 = 1'b0; en1 = 1'b1;
        sc = stop_cnt1;
        wq1.push_back({5'd31, 8'h01});
        wq1.push_back({5'd31, 8'h02});
        i2c_start();
        write_byte(8'h78, ack); chk("sat_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h1F, ack); chk("sat_ptr_ack",  32'(ack), 32'd1);
        write_byte(8'h01, ack); chk("sat_d0_ack",   32'(ack), 32'd1);
        write_byte(8'h02, ack); chk("sat_d1_ack",   32'(ack), 32'd1);
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("sat_writes_drained", 32'(wq1.size()), 32'd0);
        chk("sat_busy_after_stop", 32'(busy1), 32'd0);
        chk("sat_stop_det", 32'(stop_cnt1 - sc), 32'd1);
        en0 = 1'b1; en1 = 1'b0;

        // reset while the slave drives a read bit low
        i2c_start();
        write_byte(8'h78, ack); chk("rs_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h03, ack); chk("rs_ptr_ack",  32'(ack), 32'd1);
        i2c_stop();
        raq.push_back(5'd3); rdq.push_back(8'h00);
        i2c_start();
        write_byte(8'h79, ack); chk("rs_read_ack", 32'(ack), 32'd1);
        n = 0;
        while (sda_oe0 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("rs_sda_driven", 32'(sda_oe0), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rs_sda_oe", 32'(sda_oe0), 32'd0);
        chk("rs_scl_oe", 32'(scl_oe0), 32'd0);
        chk("rs_busy",   32'(busy0),   32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        i2c_stop();
        raq.push_back(5'd0); rdq.push_back(8'hC3);
        i2c_start();
        write_byte(8'h79, ack); chk("rs_post_ack", 32'(ack), 32'd1);
        read_byte(d, 1'b0);     chk("rs_post_data", 32'(d), 32'hC3);
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("rs_reads_drained", 32'(raq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
